// File: rtl/hit_pkg.sv
// Shared types and constants for the player hit tracker.
package hit_pkg;

  localparam int NUM_ROCKETS       = 15;
  localparam int DEF_START_LIVES   = 3;
  localparam int DEF_INVULN_FRAMES = 60;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  // Saturating decrement of the 2-bit lives counter.
  function automatic logic [1:0] lives_dec(input logic [1:0] lives);
    if (lives == 2'd0) begin
      return 2'd0;
    end else begin
      return lives - 2'd1;
    end
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector for the frame strobe, which is sampled as ordinary
// data in the pixel clock domain.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_prev_r;

  // Remember last cycle's frame strobe level.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev_r <= 1'b0;
    end else begin
      frame_prev_r <= frame_clk;
    end
  end

  assign frame_tick = frame_clk & ~frame_prev_r;

endmodule

// File: rtl/player_hit_tracker.sv
// Player hit tracker: accumulates player/rocket pixel overlaps within a
// frame, and at each frame boundary updates lives, invulnerability blink,
// game-over and the rocket hit mask.
// Optional build macro: PLAYER_HIT_MASK_EN enables the per-rocket hit mask;
// without it RockHitMask is tied to zero.
module player_hit_tracker #(
  parameter int START_LIVES   = hit_pkg::DEF_START_LIVES,
  parameter int INVULN_FRAMES = hit_pkg::DEF_INVULN_FRAMES,
  parameter int BLINK_SHIFT   = 3
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic                             is_Player,
  input  logic [hit_pkg::NUM_ROCKETS-1:0]  is_NPCRock,
  output logic [1:0]                       PlayerLives,
  output logic                             PlayerHit,
  output logic                             Player_Blink,
  output logic                             GameOver,
  output logic [hit_pkg::NUM_ROCKETS-1:0]  RockHitMask
);
  import hit_pkg::*;

  logic       frame_tick_s;
  logic       overlap_s;
  state_t     state_r, state_s;
  logic [1:0] lives_r, lives_s;
  logic [7:0] inv_cnt_r, inv_cnt_s;
  logic       hit_acc_r, hit_acc_s;
  logic       player_hit_r, player_hit_s;
  logic       blink_r, blink_s;
  logic       game_over_r, game_over_s;

  frame_edge_detect u_edge (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick_s)
  );

  assign overlap_s = is_Player && (is_NPCRock != '0);

  // Next-state logic: per-frame evaluation of the accumulated hit.
  always_comb begin
    state_s      = state_r;
    lives_s      = lives_r;
    inv_cnt_s    = inv_cnt_r;
    player_hit_s = player_hit_r;
    hit_acc_s    = hit_acc_r | overlap_s;
    if (frame_tick_s) begin
      // An overlap on the boundary cycle itself belongs to the new frame.
      hit_acc_s    = overlap_s;
      player_hit_s = 1'b0;
      case (state_r)
        ALIVE: begin
          if (hit_acc_r) begin
            lives_s      = lives_dec(lives_r);
            player_hit_s = 1'b1;
            if (lives_s == 2'd0) begin
              state_s   = DEAD;
              inv_cnt_s = 8'd0;
            end else begin
              state_s   = INVULN;
              inv_cnt_s = 8'(INVULN_FRAMES);
            end
          end else begin
            state_s = ALIVE;
          end
        end
        INVULN: begin
          if (inv_cnt_r != 8'd0) begin
            inv_cnt_s = inv_cnt_r - 8'd1;
          end else begin
            inv_cnt_s = inv_cnt_r;
          end
          if (inv_cnt_s == 8'd0) begin
            state_s = ALIVE;
          end else begin
            state_s = INVULN;
          end
        end
        DEAD: begin
          state_s = DEAD;
          lives_s = 2'd0;
        end
        default: begin
          state_s = ALIVE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    blink_s     = (state_s == INVULN) ? inv_cnt_s[BLINK_SHIFT] : 1'b0;
    game_over_s = (state_s == DEAD);
  end

  // State and registered outputs; Reset wins over any coincident event.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ALIVE;
      lives_r      <= 2'(START_LIVES);
      inv_cnt_r    <= 8'd0;
      hit_acc_r    <= 1'b0;
      player_hit_r <= 1'b0;
      blink_r      <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      lives_r      <= lives_s;
      inv_cnt_r    <= inv_cnt_s;
      hit_acc_r    <= hit_acc_s;
      player_hit_r <= player_hit_s;
      blink_r      <= blink_s;
      game_over_r  <= game_over_s;
    end
  end

`ifdef PLAYER_HIT_MASK_EN
  logic [NUM_ROCKETS-1:0] mask_acc_r;
  logic [NUM_ROCKETS-1:0] rock_mask_r;

  // Collect touching rockets per frame and publish them at the boundary,
  // regardless of state, so rockets are retired even while invulnerable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask_acc_r  <= '0;
      rock_mask_r <= '0;
    end else if (frame_tick_s) begin
      rock_mask_r <= mask_acc_r;
      mask_acc_r  <= overlap_s ? is_NPCRock : '0;
    end else if (overlap_s) begin
      mask_acc_r  <= mask_acc_r | is_NPCRock;
    end else begin
      mask_acc_r  <= mask_acc_r;
    end
  end

  assign RockHitMask = rock_mask_r;
`else
  assign RockHitMask = '0;
`endif

  assign PlayerLives  = lives_r;
  assign PlayerHit    = player_hit_r;
  assign Player_Blink = blink_r;
  assign GameOver     = game_over_r;

endmodule

// File: tb/tb_player_hit_tracker.sv
// Directed self-checking bench for player_hit_tracker (default parameters).
// Expected rocket masks follow PLAYER_HIT_MASK_EN when it is defined.
module tb_player_hit_tracker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        is_Player;
  logic [14:0] is_NPCRock;
  logic [1:0]  PlayerLives;
  logic        PlayerHit;
  logic        Player_Blink;
  logic        GameOver;
  logic [14:0] RockHitMask;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  player_hit_tracker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .is_Player    (is_Player),
    .is_NPCRock   (is_NPCRock),
    .PlayerLives  (PlayerLives),
    .PlayerHit    (PlayerHit),
    .Player_Blink (Player_Blink),
    .GameOver     (GameOver),
    .RockHitMask  (RockHitMask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_mask(input logic [14:0] m);
`ifdef PLAYER_HIT_MASK_EN
    return m;
`else
    return 15'h0000 & m;
`endif
  endfunction

  task automatic check_out(input string tag, input logic [1:0] lives, input logic hit,
                           input logic blink, input logic go, input logic [14:0] mask);
    check({tag, ".lives"}, 32'(PlayerLives),  32'(lives));
    check({tag, ".hit"},   32'(PlayerHit),    32'(hit));
    check({tag, ".blink"}, 32'(Player_Blink), 32'(blink));
    check({tag, ".gover"}, 32'(GameOver),     32'(go));
    check({tag, ".mask"},  32'(RockHitMask),  32'(exp_mask(mask)));
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic hit_pixel(input logic [14:0] rock);
    is_Player  = 1'b1;
    is_NPCRock = rock;
    step();
    is_Player  = 1'b0;
    is_NPCRock = 15'h0000;
    step();
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    is_Player = 1'b0;
    is_NPCRock = 15'h0000;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  initial begin
    logic [14:0] rk;
    logic [7:0]  inv_e;
    logic        blink_e;

    do_reset();
    check_out("reset", 2'd3, 1'b0, 1'b0, 1'b0, 15'h0000);

    // First hit: single-cycle overlap with rocket 2.
    hit_pixel(15'h0004);
    frame_edge();
    check_out("hit1", 2'd2, 1'b1, 1'b1, 1'b0, 15'h0004);

    // Invulnerable for 60 frames while being hit every frame.
    for (int k = 1; k <= 60; k++) begin
      rk = 15'h0001 << (k % 15);
      hit_pixel(rk);
      frame_edge();
      inv_e   = 8'(60 - k);
      blink_e = (k < 60) ? inv_e[3] : 1'b0;
      check_out($sformatf("inv%0d", k), 2'd2, 1'b0, blink_e, 1'b0, rk);
    end

    // Back to ALIVE: next hit costs a life.
    hit_pixel(15'h0020);
    frame_edge();
    check_out("hit2", 2'd1, 1'b1, 1'b1, 1'b0, 15'h0020);
    for (int k = 0; k < 60; k++) frame_edge();
    check_out("inv_end2", 2'd1, 1'b0, 1'b0, 1'b0, 15'h0000);

    // Third hit is fatal.
    hit_pixel(15'h0010);
    frame_edge();
    check_out("dead", 2'd0, 1'b1, 1'b0, 1'b1, 15'h0010);
    for (int k = 0; k < 3; k++) begin
      hit_pixel(15'h0010);
      frame_edge();
      check_out($sformatf("dead%0d", k), 2'd0, 1'b0, 1'b0, 1'b1, 15'h0010);
    end

    // Overlap on the boundary cycle belongs to the next frame.
    do_reset();
    check_out("reset2", 2'd3, 1'b0, 1'b0, 1'b0, 15'h0000);
    frame_clk  = 1'b1;
    is_Player  = 1'b1;
    is_NPCRock = 15'h0100;
    step();
    check_out("edge_px", 2'd3, 1'b0, 1'b0, 1'b0, 15'h0000);
    frame_clk  = 1'b0;
    is_Player  = 1'b0;
    is_NPCRock = 15'h0000;
    step();
    frame_edge();
    check_out("edge_next", 2'd2, 1'b1, 1'b1, 1'b0, 15'h0100);

    // Reset in the middle of invulnerability (inv_cnt = 30).
    for (int k = 0; k < 30; k++) frame_edge();
    check_out("inv30", 2'd2, 1'b0, 1'b1, 1'b0, 15'h0000);
    hit_pixel(15'h4000);
    Reset      = 1'b1;
    frame_clk  = 1'b1;
    is_Player  = 1'b1;
    is_NPCRock = 15'h0002;
    step();
    check_out("mid_rst", 2'd3, 1'b0, 1'b0, 1'b0, 15'h0000);
    Reset      = 1'b0;
    frame_clk  = 1'b0;
    is_Player  = 1'b0;
    is_NPCRock = 15'h0000;
    step();
    hit_pixel(15'h0008);
    frame_edge();
    check_out("post_rst", 2'd2, 1'b1, 1'b1, 1'b0, 15'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_hit_tracker.md
PLAYER_HIT_TRACKER -- requirements
Module: player_hit_tracker

Interface
REQ-001 SHALL have parameter START_LIVES, default 3: lives loaded at reset (1..3).
REQ-002 SHALL have parameter INVULN_FRAMES, default 60: frames of invulnerability after a non-fatal hit (1..255).
REQ-003 SHALL have parameter BLINK_SHIFT, default 3: Player_Blink toggles every 2^BLINK_SHIFT frames while invulnerable.
REQ-004 SHALL have ports: Clk in 1, the system pixel clock; this is the only clock.
REQ-005 SHALL have ports: Reset in 1, synchronous, active-high.
REQ-006 SHALL have ports: frame_clk in 1, the frame strobe level, sampled as data; its rising edge marks a frame boundary.
REQ-007 SHALL have ports: is_Player in 1, the current pixel is opaque player ship.
REQ-008 SHALL have ports: is_NPCRock in 15, per-rocket pixel hit from the NPC rocket stage.
REQ-009 SHALL have ports: PlayerLives out 2, lives remaining.
REQ-010 SHALL have ports: PlayerHit out 1, high for exactly one frame after a registered hit.
REQ-011 SHALL have ports: Player_Blink out 1, the renderer suppresses the ship when high.
REQ-012 SHALL have ports: GameOver out 1.
REQ-013 SHALL have ports: RockHitMask out 15, the rockets that touched the player in the previous frame.

Function
REQ-014 SHALL detect the frame edge as frame_clk=1 with the previous registered frame_clk=0, giving one-Clk latency.
REQ-015 SHALL, on every Clk where is_Player=1 and is_NPCRock≠0, set hit_acc and OR is_NPCRock into mask_acc.
REQ-016 SHALL, on a frame-edge cycle, evaluate hit_acc/mask_acc, then clear both; an overlapping pixel on that same cycle counts toward the next frame.
REQ-017 SHALL implement states ALIVE, INVULN, DEAD.
REQ-018 SHALL, in ALIVE with hit_acc=1 at a frame edge, decrement lives saturating at 0 and assert PlayerHit; go to DEAD if the new lives=0, else go to INVULN with inv_cnt=INVULN_FRAMES.
REQ-019 SHALL, in INVULN, ignore hit_acc and decrement inv_cnt at each frame edge; on the frame edge where inv_cnt reaches 0, return to ALIVE.
REQ-020 SHALL, in DEAD, hold GameOver=1, PlayerLives=0, Player_Blink=0 and ignore hits until Reset.
REQ-021 SHALL hold PlayerHit from one frame edge until the next, then deassert it unless re-armed; re-arming cannot occur in INVULN.
REQ-022 SHALL drive Player_Blink = inv_cnt[BLINK_SHIFT] in INVULN, and 0 otherwise.
REQ-023 SHALL update RockHitMask at each frame edge to mask_acc, independent of state, so rockets are retired even while invulnerable.
REQ-024 SHALL size inv_cnt at 8 bits, with no wrap-around: a decrement at 0 is not performed.

Reset
REQ-025 SHALL, on Reset, set state=ALIVE, lives=START_LIVES, inv_cnt=0, hit_acc=0, mask_acc=0, and the previous frame_clk register=0.
REQ-026 SHALL, on Reset, drive outputs PlayerLives=START_LIVES, PlayerHit=0, Player_Blink=0, GameOver=0, RockHitMask=0.
REQ-027 SHALL give Reset priority over a coincident frame edge or hit pixel; a reset mid-INVULN returns to ALIVE with no blink.

Configuration
REQ-028 SHALL use macro PLAYER_HIT_MASK_EN: when defined, mask_acc and RockHitMask behave per REQ-015/023.
REQ-029 SHALL, when PLAYER_HIT_MASK_EN is undefined, omit the mask_acc register and tie RockHitMask to 0; all other behaviour is identical.

Structure
REQ-030 SHALL place the state enum (ALIVE, INVULN, DEAD), NUM_ROCKETS=15, and the default START_LIVES/INVULN_FRAMES constants in shared package hit_pkg.
REQ-031 SHALL implement frame-edge detection as sub-module frame_edge_detect (Clk, Reset, frame_clk -> frame_tick).

Verification
REQ-032 SHALL verify: with defaults, overlap is_Player=1 and is_NPCRock=15'h0004 for 1 Clk in frame 0 -> at the next frame edge, PlayerLives 3->2, PlayerHit=1 for one frame, RockHitMask=15'h0004, state INVULN.
REQ-033 SHALL verify: hit pixels every frame for 60 frames after the first hit -> lives remain 2, Player_Blink toggles every 8 frames, ALIVE after 60 frame edges, next hit -> lives 1.
REQ-034 SHALL verify: three separated hits -> lives 0, GameOver=1; further hits and frame edges leave all outputs unchanged.
REQ-035 SHALL verify: an overlap pixel on exactly the frame-edge Clk -> no hit in the current evaluation, and the hit is registered at the following edge.
REQ-036 SHALL verify: Reset asserted mid-INVULN with inv_cnt=30 -> next Clk shows lives=3, Blink=0, ALIVE, RockHitMask=0.
REQ-037 SHALL verify: build without PLAYER_HIT_MASK_EN, repeat REQ-032 -> RockHitMask stays 15'h0000 and lives/PlayerHit are identical.
